// File: rtl/data_ram_be.sv
// Byte-enabled 32-bit data RAM with a request/response handshake, optional wait states,
// and selectable big/little-endian lane mapping for sub-word loads and stores.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | ready for a request; req_ready high
// S_WAIT | request latched, counting down wait states
// S_RESP | one-cycle response strobe; memory was accessed on entry
module data_ram_be #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state, state_nxt;
    logic [3:0]        cnt;
    logic              access;

    logic              lat_we;
    logic [ADDR_W+1:0] lat_addr;
    logic [1:0]        lat_size;
    logic              lat_uns;
    logic [31:0]       lat_wdata;

    logic              a_we;
    logic [ADDR_W+1:0] a_addr;
    logic [1:0]        a_size;
    logic              a_uns;
    logic [31:0]       a_wdata;

    logic [1:0]        off;
    logic [ADDR_W-1:0] idx;
    logic              a_err;
    logic [1:0]        byte_lane;
    logic [1:0]        half_lane;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic              mem_we;
    logic [31:0]       rd_word;
    logic [31:0]       shifted;
    logic [31:0]       load_val;

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        access     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                        access    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    access    = 1'b1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_wdata <= 32'd0;
        end else if (state == S_IDLE && req_valid) begin
            cnt       <= CNT_LOAD;
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_size  <= req_size;
            lat_uns   <= req_unsigned;
            lat_wdata <= req_wdata;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // With no wait states the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state == S_IDLE) begin
            a_we    = req_we;
            a_addr  = req_addr;
            a_size  = req_size;
            a_uns   = req_unsigned;
            a_wdata = req_wdata;
        end else begin
            a_we    = lat_we;
            a_addr  = lat_addr;
            a_size  = lat_size;
            a_uns   = lat_uns;
            a_wdata = lat_wdata;
        end
    end

    assign off       = a_addr[1:0];
    assign idx       = a_addr[ADDR_W+1:2];
    assign a_err     = (a_size == 2'b11) || (a_size == 2'b01 && off[0]) ||
                       (a_size == 2'b10 && off != 2'b00);
    assign byte_lane = BIG_ENDIAN ? ~off : off;
    assign half_lane = BIG_ENDIAN ? {~off[1], 1'b0} : {off[1], 1'b0};

    always_comb begin
        case (a_size)
            2'b00: begin
                be    = 4'b0001 << byte_lane;
                lane  = byte_lane;
                wword = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << half_lane;
                lane  = half_lane;
                wword = {2{a_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                lane  = 2'd0;
                wword = a_wdata;
            end
        endcase
    end

    // Gated by rst_n so a request presented while reset is held never commits.
    assign mem_we = access && a_we && !a_err && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[idx];
    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        case (a_size)
            2'b00:   load_val = a_uns ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = a_uns ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (access) begin
            resp_err   <= a_err;
            resp_rdata <= (a_err || a_we) ? 32'd0 : load_val;
        end
    end

endmodule

// File: tb/tb_data_ram_be.sv
// Directed bench for data_ram_be: three instances cover zero/three wait states (big-endian)
// and one wait state little-endian; vectors carry hand-computed expected results.
module tb_data_ram_be;

    logic        clk;
    logic        rst_n        [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [11:0] req_addr     [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_wdata    [3];
    logic        resp_valid   [3];
    logic [31:0] resp_rdata   [3];
    logic        resp_err     [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_ram_be #(
            .ADDR_W     (10),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 1)),
            .BIG_ENDIAN (g == 2 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n[g]),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_we      (req_we[g]),
            .req_addr    (req_addr[g]),
            .req_size    (req_size[g]),
            .req_unsigned(req_unsigned[g]),
            .req_wdata   (req_wdata[g]),
            .resp_valid  (resp_valid[g]),
            .resp_rdata  (resp_rdata[g]),
            .resp_err    (resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    typedef struct {
        int          d;
        logic        we;
        logic [11:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int d, input logic we, input logic [11:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.d = d; v.we = we; v.addr = addr; v.size = size; v.uns = uns;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic int exp_lat(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One request; returns response data, cycles spent waiting, and whether handshake timing held.
    task automatic xact(input int d, input logic we, input logic [11:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b1;
        rd   = 32'hxxxxxxxx;
        er   = 1'bx;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_size[d] = size; req_unsigned[d] = uns; req_wdata[d] = wd;
        if (req_ready[d] !== 1'b1) ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid[d] === 1'b1) begin
                seen = 1'b1;
                rd   = resp_rdata[d];
                er   = resp_err[d];
                if (req_ready[d] !== 1'b0) ok = 1'b0;
            end else begin
                if (req_ready[d] !== 1'b0) ok = 1'b0;
                lat++;
            end
        end
        if (!seen) lat = -1;
        @(negedge clk);
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) ok = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          ok;
    int          cnt;
    bit          seen;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_size[d] = 2'b00; req_unsigned[d] = 1'b0; req_wdata[d] = 32'd0;
        end

        // dut0: WAIT_CYCLES=0, big-endian
        vecs.push_back(mk(0, 1, 12'h010, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk(0, 0, 12'h010, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, 12'h011, 2'b00, 0, 32'hFFFFFF11, 32'h0, 0));
        vecs.push_back(mk(0, 0, 12'h010, 2'b10, 0, 32'h0, 32'hDE11BEEF, 0));
        vecs.push_back(mk(0, 0, 12'h010, 2'b00, 0, 32'h0, 32'hFFFFFFDE, 0));
        vecs.push_back(mk(0, 0, 12'h010, 2'b00, 1, 32'h0, 32'h000000DE, 0));
        vecs.push_back(mk(0, 0, 12'h012, 2'b01, 0, 32'h0, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(0, 0, 12'h012, 2'b10, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 12'h013, 2'b01, 0, 32'h0000FFFF, 32'h0, 1));
        vecs.push_back(mk(0, 0, 12'h010, 2'b11, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 12'h010, 2'b11, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 12'h010, 2'b10, 0, 32'h0, 32'hDE11BEEF, 0));
        vecs.push_back(mk(0, 0, 12'h010, 2'b01, 1, 32'h0, 32'h0000DE11, 0));
        vecs.push_back(mk(0, 0, 12'h011, 2'b00, 0, 32'h0, 32'h00000011, 0));
        vecs.push_back(mk(0, 0, 12'h013, 2'b00, 0, 32'h0, 32'hFFFFFFEF, 0));
        vecs.push_back(mk(0, 1, 12'h010, 2'b01, 0, 32'h12348001, 32'h0, 0));
        vecs.push_back(mk(0, 1, 12'h013, 2'b00, 0, 32'h000000AA, 32'h0, 0));
        vecs.push_back(mk(0, 0, 12'h012, 2'b01, 0, 32'h0, 32'hFFFFBEAA, 0));
        vecs.push_back(mk(0, 0, 12'h012, 2'b01, 1, 32'h0, 32'h0000BEAA, 0));
        vecs.push_back(mk(0, 1, 12'hFFC, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0));
        vecs.push_back(mk(0, 0, 12'hFFC, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 0, 12'h010, 2'b10, 0, 32'h0, 32'h8001BEAA, 0));
        // dut1: WAIT_CYCLES=3, big-endian
        vecs.push_back(mk(1, 1, 12'h020, 2'b10, 0, 32'hA5A5A5A5, 32'h0, 0));
        vecs.push_back(mk(1, 1, 12'h024, 2'b10, 0, 32'h0BADF00D, 32'h0, 0));
        vecs.push_back(mk(1, 0, 12'h024, 2'b10, 0, 32'h0, 32'h0BADF00D, 0));
        vecs.push_back(mk(1, 0, 12'h025, 2'b00, 1, 32'h0, 32'h000000AD, 0));
        // dut2: WAIT_CYCLES=1, little-endian
        vecs.push_back(mk(2, 1, 12'h040, 2'b10, 0, 32'h11223344, 32'h0, 0));
        vecs.push_back(mk(2, 0, 12'h040, 2'b00, 0, 32'h0, 32'h00000044, 0));
        vecs.push_back(mk(2, 0, 12'h043, 2'b00, 1, 32'h0, 32'h00000011, 0));
        vecs.push_back(mk(2, 0, 12'h041, 2'b00, 0, 32'h0, 32'h00000033, 0));
        vecs.push_back(mk(2, 0, 12'h042, 2'b01, 0, 32'h0, 32'h00001122, 0));
        vecs.push_back(mk(2, 0, 12'h040, 2'b01, 1, 32'h0, 32'h00003344, 0));
        vecs.push_back(mk(2, 1, 12'h040, 2'b00, 0, 32'h00000099, 32'h0, 0));
        vecs.push_back(mk(2, 0, 12'h040, 2'b10, 0, 32'h0, 32'h11223399, 0));
        vecs.push_back(mk(2, 1, 12'h042, 2'b01, 0, 32'h0000ABCD, 32'h0, 0));
        vecs.push_back(mk(2, 0, 12'h040, 2'b10, 0, 32'h0, 32'hABCD3399, 0));
        vecs.push_back(mk(2, 0, 12'h042, 2'b01, 0, 32'h0, 32'hFFFFABCD, 0));
        vecs.push_back(mk(2, 0, 12'h043, 2'b00, 0, 32'h0, 32'hFFFFFFAB, 0));
        vecs.push_back(mk(2, 0, 12'h041, 2'b10, 0, 32'h0, 32'h0, 1));

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d resp_valid", d), {31'd0, resp_valid[d]}, 32'd0);
            chk($sformatf("rst%0d resp_rdata", d), resp_rdata[d], 32'd0);
            chk($sformatf("rst%0d resp_err", d), {31'd0, resp_err[d]}, 32'd0);
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("rst%0d req_ready", d), {31'd0, req_ready[d]}, 32'd1);

        foreach (vecs[i]) begin
            xact(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                 rd, er, lat, ok);
            chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i].d)));
            chk($sformatf("v%0d handshake", i), {31'd0, ok}, 32'd1);
        end

        // response data holds while idle
        repeat (4) @(negedge clk);
        chk("hold rdata", resp_rdata[0], 32'h8001BEAA);
        chk("hold valid", {31'd0, resp_valid[0]}, 32'd0);

        // request held valid with changing inputs: only the latched load runs, next accept in IDLE
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 12'h024;
        req_size[1] = 2'b10; req_unsigned[1] = 1'b0; req_wdata[1] = 32'd0;
        @(posedge clk);
        #1;
        req_we[1] = 1'b1; req_wdata[1] = 32'hFFFFFFFF; req_addr[1] = 12'h024;
        cnt = 0; seen = 1'b0; rd = 32'd0; er = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid[1] === 1'b1) begin
                seen = 1'b1; rd = resp_rdata[1]; er = resp_err[1];
            end else begin
                cnt++;
            end
            #2 req_addr[1] = 12'h024 ^ 12'(i << 4);
            req_addr[1] = 12'h024;
        end
        chk("held first latency", 32'(cnt), 32'd3);
        chk("held first rdata", rd, 32'h0BADF00D);
        chk("held first err", {31'd0, er}, 32'd0);
        @(negedge clk);
        chk("held idle ready", {31'd0, req_ready[1]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        cnt = 0; seen = 1'b0; rd = 32'hxxxxxxxx;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid[1] === 1'b1) begin
                seen = 1'b1; rd = resp_rdata[1]; er = resp_err[1];
            end else begin
                cnt++;
            end
        end
        chk("held second latency", 32'(cnt), 32'd3);
        chk("held second rdata", rd, 32'd0);
        @(negedge clk);
        xact(1, 0, 12'h024, 2'b10, 0, 32'd0, rd, er, lat, ok);
        chk("held store landed", rd, 32'hFFFFFFFF);

        // reset in the middle of WAIT aborts the store
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 12'h020;
        req_size[1] = 2'b10; req_wdata[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk("abort rst rdata", resp_rdata[1], 32'd0);
        chk("abort rst valid", {31'd0, resp_valid[1]}, 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid[1] === 1'b1) cnt++;
        end
        chk("abort no response", 32'(cnt), 32'd0);
        xact(1, 0, 12'h020, 2'b10, 0, 32'd0, rd, er, lat, ok);
        chk("abort mem kept", rd, 32'hA5A5A5A5);
        chk("abort lw latency", 32'(lat), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_be.md
DATA_RAM_BE -- requirements
Module: data_ram_be

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; depth = 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 0, extra access wait states, legal range 0..15.
REQ-003 Parameter BIG_ENDIAN, default 1; 1 = MIPS big-endian lane order, 0 = little-endian.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_W+2  byte address; [ADDR_W+1:2] word index, [1:0] byte offset.
REQ-010 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-012 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 resp_valid  output  1  one-cycle response strobe.
REQ-014 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  misaligned or illegal-size request, qualified by resp_valid.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept on edge with req_valid && req_ready; latch we, addr, size, unsigned, wdata; later input changes ignored.
REQ-018 On accept: WAIT_CYCLES = 0 -> RESP; else -> WAIT with counter loaded to WAIT_CYCLES-1.
REQ-019 WAIT: counter decrements each cycle; at count 0 -> RESP.
REQ-020 Memory access (write commit or read capture) at the edge entering RESP; read is synchronous.
REQ-021 RESP lasts exactly one cycle with resp_valid = 1, then -> IDLE; no response back-pressure.
REQ-022 Latency: accept at edge E -> resp_valid high in cycle after edge E+WAIT_CYCLES; throughput one request per WAIT_CYCLES+2 cycles.
REQ-023 Error: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> resp_err=1, resp_rdata=0, no memory write.
REQ-024 Big-endian lanes: byte offset 0 = [31:24] ... offset 3 = [7:0]; half offset 0 = [31:16], offset 2 = [15:0]; BIG_ENDIAN=0 mirrors (offset 0 = [7:0]).
REQ-025 Stores write only the addressed lanes (per-byte enable); other bytes of the word unchanged.
REQ-026 Loads: selected lane extended to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-027 Stores respond resp_valid=1, resp_err=0, resp_rdata=0.
REQ-028 resp_rdata and resp_err are registered and hold their last value until next RESP; outputs are 0 outside RESP only after reset.
REQ-029 Same-word store followed by load returns newly written data (no stale read).

Reset
REQ-030 rst_n low: FSM -> IDLE, counter 0, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-031 Reset during WAIT aborts the request: no write commit, no response.
REQ-032 Memory array is not cleared by reset; contents survive reset.

Verification
REQ-033 WAIT_CYCLES=0: sw 0xDEADBEEF @0x010, then lw @0x010 -> resp_valid 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
REQ-034 Big-endian lanes: after word above, sb 0x11 @0x011 then lw @0x010 -> 0xDE11BEEF; lb @0x010 -> 0xFFFFFFDE; lbu -> 0x000000DE; lh @0x012 -> 0xFFFFBEEF.
REQ-035 Misalignment: lw @0x012, sh @0x013, size=11 -> each resp_err=1, rdata=0; following lw @0x010 unchanged 0xDE11BEEF.
REQ-036 WAIT_CYCLES=3: accept at edge E -> req_ready=0 and resp_valid=0 until cycle after E+3, resp_valid exactly one cycle, req_ready=1 next cycle.
REQ-037 Reset mid-WAIT (WAIT_CYCLES=3, sw 0x12345678 @0x020, rst_n low in cycle 2) -> no response; lw @0x020 after reset returns prior contents.
REQ-038 Back-to-back req_valid held high with changing inputs during WAIT -> only latched request executed; next accepted only in IDLE.
